// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU operation sequencer and its command FIFO.
package alu_seq_pkg;

   localparam int DATA_W = 5;
   localparam int OP_W   = 4;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              cin;
   } alu_cmd_t;

   localparam int CMD_W = $bits(alu_cmd_t);

   function automatic logic op_is_legal(input logic [OP_W-1:0] op, input int num_ops);
      return int'(op) < num_ops;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer; full/empty come from a registered occupancy count.
module alu_cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic [CMD_W-1:0] push_data,
   input  logic             pop,
   output logic [CMD_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   alu_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage is not reset; pointers and count alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the combinational ALU from a buffered command stream, waits for the result
// to settle, and returns each captured result over a valid/ready response stream.
module alu_op_sequencer #(
   parameter int DATA_W        = 5,
   parameter int OP_W          = 4,
   parameter int NUM_OPS       = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [OP_W-1:0]   CMD_OP,
   input  logic [DATA_W-1:0] CMD_A,
   input  logic [DATA_W-1:0] CMD_B,
   input  logic              CMD_CIN,
   output logic [OP_W-1:0]   MUX_SELECT,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              CIN,
   input  logic [DATA_W-1:0] SUM,
   input  logic              COUT,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_SUM,
   output logic              RSP_COUT,
   output logic [OP_W-1:0]   RSP_OP,
   output logic              RSP_ERR,
   output logic              BUSY,
   output logic [CNT_W-1:0]  OP_COUNT
);
   import alu_seq_pkg::*;

   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   state_t        state_q;
   state_t        state_d;
   alu_cmd_t      cmd_in;
   alu_cmd_t      head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          head_legal;
   logic          load_alu;
   logic          load_err;
   logic          capture;
   logic          rsp_fire;
   logic [SW-1:0] settle_cnt;

   assign cmd_in     = '{op: CMD_OP, a: CMD_A, b: CMD_B, cin: CMD_CIN};
   assign CMD_READY  = !fifo_full;
   assign head_legal = op_is_legal(head.op, NUM_OPS);
   assign RSP_VALID  = (state_q == RESP);
   assign BUSY       = (state_q != IDLE) || !fifo_empty;

   alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .push     (CMD_VALID && CMD_READY),
      .push_data(cmd_in),
      .pop      (fifo_pop),
      .pop_data (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = head_legal ? SETTLE : RESP;
         SETTLE:  if (settle_cnt == SW'(1)) state_d = RESP;
         RESP:    if (RSP_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = 1'b0;
      load_alu = 1'b0;
      load_err = 1'b0;
      capture  = 1'b0;
      rsp_fire = 1'b0;
      case (state_q)
         IDLE: begin
            fifo_pop = !fifo_empty;
            load_alu = !fifo_empty && head_legal;
            load_err = !fifo_empty && !head_legal;
         end
         SETTLE:  capture  = (settle_cnt == SW'(1));
         RESP:    rsp_fire = RSP_READY;
         default: ;
      endcase
   end

   // ALU ports only move on a legal pop, so they keep the last operation between commands.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         MUX_SELECT <= '0;
         A          <= '0;
         B          <= '0;
         CIN        <= 1'b0;
         settle_cnt <= '0;
         RSP_SUM    <= '0;
         RSP_COUT   <= 1'b0;
         RSP_OP     <= '0;
         RSP_ERR    <= 1'b0;
         OP_COUNT   <= '0;
      end else begin
         if (load_alu) begin
            MUX_SELECT <= head.op;
            A          <= head.a;
            B          <= head.b;
            CIN        <= head.cin;
            settle_cnt <= SW'(SETTLE_CYCLES);
         end else if (state_q == SETTLE) begin
            settle_cnt <= settle_cnt - SW'(1);
         end
         if (capture) begin
            RSP_SUM  <= SUM;
            RSP_COUT <= COUT;
            RSP_OP   <= MUX_SELECT;
            RSP_ERR  <= 1'b0;
         end
         if (load_err) begin
            RSP_SUM  <= '0;
            RSP_COUT <= 1'b0;
            RSP_OP   <= head.op;
            RSP_ERR  <= 1'b1;
         end
         if (rsp_fire) OP_COUNT <= OP_COUNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed and randomized commands against a queue-based
// response model, with one instance at SETTLE_CYCLES=1 and one at 3 behind a slow ALU stub.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       cmd_valid, cmd_valid_3, rsp_ready, rsp_ready_3;
   logic [3:0] cmd_op;
   logic [4:0] cmd_a, cmd_b;
   logic       cmd_cin;

   logic        cmd_ready, cin, cout, rsp_valid, rsp_cout, rsp_err, busy;
   logic [3:0]  mux_select, rsp_op;
   logic [4:0]  a, b, sum, rsp_sum;
   logic [15:0] op_count;

   logic        cmd_ready_3, cin_3, cout_3, rsp_valid_3, rsp_cout_3, rsp_err_3, busy_3;
   logic [3:0]  mux_select_3, rsp_op_3;
   logic [4:0]  a_3, b_3, sum_3, rsp_sum_3;
   logic [15:0] op_count_3;

   // ALU stub: op0 = A+B+CIN, op1 = A-B, op2 = A&B; result is {COUT, SUM}.
   function automatic logic [5:0] alu_ref(input logic [3:0] op, input logic [4:0] av,
                                          input logic [4:0] bv, input logic c);
      case (op)
         4'd0:    return {1'b0, av} + {1'b0, bv} + {5'd0, c};
         4'd1:    return {1'b0, av} - {1'b0, bv};
         4'd2:    return {1'b0, av & bv};
         default: return 6'd0;
      endcase
   endfunction

   assign {cout, sum} = alu_ref(mux_select, a, b, cin);

   // Slow stub: SUM/COUT follow an input change only two cycles later.
   logic [5:0] dly1 = 6'd0, dly2 = 6'd0;
   always @(posedge clk) begin
      dly1 <= alu_ref(mux_select_3, a_3, b_3, cin_3);
      dly2 <= dly1;
   end
   assign {cout_3, sum_3} = dly2;

   alu_op_sequencer u_dut (
      .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_OP(cmd_op), .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_CIN(cmd_cin),
      .MUX_SELECT(mux_select), .A(a), .B(b), .CIN(cin), .SUM(sum), .COUT(cout),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_SUM(rsp_sum), .RSP_COUT(rsp_cout),
      .RSP_OP(rsp_op), .RSP_ERR(rsp_err), .BUSY(busy), .OP_COUNT(op_count)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
      .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid_3), .CMD_READY(cmd_ready_3),
      .CMD_OP(cmd_op), .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_CIN(cmd_cin),
      .MUX_SELECT(mux_select_3), .A(a_3), .B(b_3), .CIN(cin_3), .SUM(sum_3), .COUT(cout_3),
      .RSP_VALID(rsp_valid_3), .RSP_READY(rsp_ready_3), .RSP_SUM(rsp_sum_3),
      .RSP_COUT(rsp_cout_3), .RSP_OP(rsp_op_3), .RSP_ERR(rsp_err_3), .BUSY(busy_3),
      .OP_COUNT(op_count_3)
   );

   typedef struct {
      logic [3:0] op;
      logic       err;
      logic [5:0] res;
   } rsp_t;

   rsp_t        exp_q[$];
   int          exp_count;
   logic [14:0] last_ports;
   int          n_tests;
   int          n_fail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every accepted command yields exactly one response, in order.
   function automatic void model_accept(input logic [3:0] op, input logic [4:0] av,
                                        input logic [4:0] bv, input logic c);
      rsp_t r;
      r.op = op;
      if (op < 4'd3) begin
         r.err      = 1'b0;
         r.res      = alu_ref(op, av, bv, c);
         last_ports = {op, av, bv, c};
      end else begin
         r.err = 1'b1;
         r.res = 6'd0;
      end
      exp_q.push_back(r);
   endfunction

   task automatic push_cmd(input logic [3:0] op, input logic [4:0] av, input logic [4:0] bv,
                           input logic c, input int budget, output bit ok);
      cmd_op = op; cmd_a = av; cmd_b = bv; cmd_cin = c;
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            model_accept(op, av, bv, c);
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag);
      rsp_t e;
      int   n;
      rsp_ready = 1'b1;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " rsp_valid"}, rsp_valid, 1);
      e = exp_q.pop_front();
      check({tag, " {op,err,cout,sum}"}, {rsp_op, rsp_err, rsp_cout, rsp_sum},
            {e.op, e.err, e.res});
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_count++;
      check({tag, " op_count"}, op_count, exp_count & 32'hFFFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      bit         seen;
      int         edges;
      int         nb;
      logic [3:0] op_r;

      n_tests = 0; n_fail = 0; exp_count = 0; last_ports = '0;
      cmd_valid = 0; cmd_valid_3 = 0; rsp_ready = 0; rsp_ready_3 = 0;
      cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_cin = 0;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset alu ports", {mux_select, a, b, cin}, 0);
      check("reset rsp fields", {rsp_valid, rsp_sum, rsp_cout, rsp_op, rsp_err}, 0);
      check("reset op_count/busy", {op_count, busy}, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("cmd_ready after reset", cmd_ready, 1);
      check("busy after reset", busy, 0);

      // Single add with cycle-accurate latency.
      push_cmd(4'd0, 5'h08, 5'h11, 1'b0, 4, ok);
      check("add accepted", ok, 1);
      edges = 0;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check("add rsp_valid cycle", 1 + edges, 3);
      get_rsp("add");
      check("add alu ports", {mux_select, a, b, cin}, last_ports);

      push_cmd(4'd0, 5'h1F, 5'h01, 1'b0, 4, ok);
      get_rsp("carry wrap 1");
      push_cmd(4'd0, 5'h1F, 5'h1F, 1'b1, 4, ok);
      get_rsp("carry wrap 2");

      // Back-pressure: 1 in flight + 4 buffered, then the 6th must wait.
      for (int i = 0; i < 5; i++) begin
         push_cmd(4'(i % 3), 5'($urandom), 5'($urandom), 1'($urandom), 1, ok);
         check($sformatf("burst push %0d accepted", i), ok, 1);
      end
      check("cmd_ready low when full", cmd_ready, 0);
      cmd_op = 4'd1; cmd_a = 5'h04; cmd_b = 5'h09; cmd_cin = 1'b0;
      cmd_valid = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cmd_ready) seen = 1'b1;
      end
      cmd_valid = 1'b0;
      check("6th held while full", seen, 0);
      check("busy while stalled", busy, 1);
      get_rsp("full rsp0");
      check("cmd_ready low on pop cycle", cmd_ready, 0);
      @(posedge clk); #1;
      check("cmd_ready after pop", cmd_ready, 1);
      push_cmd(4'd1, 5'h04, 5'h09, 1'b0, 4, ok);
      check("6th accepted", ok, 1);
      while (exp_q.size() != 0) get_rsp("full drain");
      check("full test alu ports", {mux_select, a, b, cin}, last_ports);

      // Illegal opcode: error response, ALU ports untouched.
      push_cmd(4'hA, 5'h03, 5'h00, 1'b0, 4, ok);
      edges = 0;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check("illegal rsp_valid cycle", 1 + edges, 2);
      get_rsp("illegal");
      check("illegal keeps alu ports", {mux_select, a, b, cin}, last_ports);

      // Random bursts drained in order against the model.
      repeat (10) begin
         nb = $urandom_range(1, 5);
         for (int i = 0; i < nb; i++) begin
            op_r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15))
                                               : 4'($urandom_range(0, 2));
            push_cmd(op_r, 5'($urandom), 5'($urandom), 1'($urandom), 4, ok);
            check("rand push accepted", ok, 1);
         end
         while (exp_q.size() != 0) get_rsp("rand rsp");
         check("rand alu ports", {mux_select, a, b, cin}, last_ports);
      end

      // Settle timing on the SETTLE_CYCLES=3 instance with the slow stub.
      check("dut3 ready", cmd_ready_3, 1);
      cmd_op = 4'd0; cmd_a = 5'h0A; cmd_b = 5'h07; cmd_cin = 1'b1;
      cmd_valid_3 = 1'b1;
      @(posedge clk); #1;
      cmd_valid_3 = 1'b0;
      edges = 0;
      while (!rsp_valid_3 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check("settle3 rsp_valid cycle", 1 + edges, 5);
      check("settle3 {op,err,cout,sum}", {rsp_op_3, rsp_err_3, rsp_cout_3, rsp_sum_3},
            {4'd0, 1'b0, alu_ref(4'd0, 5'h0A, 5'h07, 1'b1)});
      rsp_ready_3 = 1'b1;
      @(posedge clk); #1;
      rsp_ready_3 = 1'b0;
      check("settle3 op_count", op_count_3, 1);

      // Reset during SETTLE with two commands still queued.
      cmd_valid_3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_op = 4'd2; cmd_a = 5'(5'h11 + i); cmd_b = 5'h1C; cmd_cin = 1'b0;
         @(posedge clk); #1;
      end
      cmd_valid_3 = 1'b0;
      check("dut3 mid-op ports", {mux_select_3, a_3}, {4'd2, 5'h11});
      check("dut3 mid-op busy", busy_3, 1);
      rst_n = 1'b0;
      #1;
      check("mid-op reset dut3 ports", {mux_select_3, a_3, b_3, cin_3}, 0);
      check("mid-op reset dut3 rsp", {rsp_valid_3, rsp_sum_3, rsp_cout_3, rsp_op_3, rsp_err_3,
                                      busy_3, op_count_3}, 0);
      check("mid-op reset dut op_count", op_count, 0);
      exp_count = 0;
      exp_q.delete();
      last_ports = '0;
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset dut3 busy", busy_3, 0);
      check("post-reset dut3 cmd_ready", cmd_ready_3, 1);
      seen = 1'b0;
      rsp_ready_3 = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid_3 || busy_3) seen = 1'b1;
      end
      rsp_ready_3 = 1'b0;
      check("no response after reset", seen, 0);

      push_cmd(4'd1, 5'h05, 5'h07, 1'b0, 4, ok);
      get_rsp("post-reset sub");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
